// File: rtl/serial_frame_tx_if.sv
// Word handshake and serial line bundle for serial_frame_tx.
// master drives the word side; slave is the transmitter.
interface serial_frame_tx_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         so;
    logic         busy;
    logic         done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  so,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output so,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: start 0, N data bits LSB first, [even parity], stop 1; optional parity via SERIAL_FRAME_TX_PARITY_EN.
// Latency: start bit appears on the acceptance edge, done pulses F*CLKS_PER_BIT cycles later.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, never queued.
module serial_frame_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    serial_frame_tx_if.slave  tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
    logic par_q, par_d;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [N-1:0]     shreg_q, shreg_d, shreg_sh;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_cyc;

    assign tx.in_ready = (state_q == S_IDLE);
    assign tx.so       = so_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        so_d     = so_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d    = par_q;
`endif
        shreg_sh = shreg_q >> 1;
        last_cyc = (cnt_q == CNT_MAX);

        case (state_q)
            S_IDLE: begin
                if (tx.in_valid) begin
                    state_d = S_START;
                    shreg_d = tx.in_data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    so_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    par_d   = ^tx.in_data;
`endif
                end
            end
            S_START: begin
                if (last_cyc) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    so_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (last_cyc) begin
                    cnt_d   = '0;
                    shreg_d = shreg_sh;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = S_PARITY;
                        so_d    = par_q;
`else
                        state_d = S_STOP;
                        so_d    = 1'b1;
`endif
                    end else begin
                        so_d = shreg_sh[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                if (last_cyc) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    so_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (last_cyc) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                so_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            so_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: scoreboard of expected line bits per cycle.
module tb_serial_frame_tx;
    localparam int N = 8;
    localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int F = N + 3;
`else
    localparam int F = N + 2;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    serial_frame_tx_if #(.N(N)) tx0 ();
    serial_frame_tx_if #(.N(N)) tx1 ();

    serial_frame_tx #(.N(N), .CLKS_PER_BIT(C)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tx      (tx0)
    );

    serial_frame_tx #(.N(N), .CLKS_PER_BIT(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .tx      (tx1)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_acc;
    logic exp_q[$];
    logic exp1_q[$];
    int   acc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx0.in_valid && tx0.in_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pop0();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    function automatic logic pop1();
        if (exp1_q.size() == 0) return 1'bx;
        return exp1_q.pop_front();
    endfunction

    // Expected line level for every cycle of one frame.
    task automatic push_frame(input logic [N-1:0] d, input bit fast);
        logic b;
        int   c;
        c = fast ? 1 : C;
        for (int idx = 0; idx < F; idx++) begin
            if (idx == 0)                      b = 1'b0;
            else if (idx <= N)                 b = d[idx-1];
            else if (idx == N + 1 && F == N + 3) b = ^d;
            else                               b = 1'b1;
            for (int r = 0; r < c; r++) begin
                if (fast) exp1_q.push_back(b);
                else      exp_q.push_back(b);
            end
        end
    endtask

    task automatic send0(input logic [N-1:0] d);
        tx0.in_data  = d;
        tx0.in_valid = 1'b1;
        push_frame(d, 1'b0);
        @(posedge clk);
        #1 tx0.in_valid = 1'b0;
    endtask

    task automatic run_frame(input int glitch_at, input int abort_at);
        for (int i = 0; i < F * C; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_so", tx0.so, 1);
                chk("abort_busy", tx0.busy, 0);
                chk("abort_done", tx0.done, 0);
                chk("abort_rdy", tx0.in_ready, 1);
                exp_q.delete();
                return;
            end
            chk("so", tx0.so, pop0());
            chk("busy", tx0.busy, 1);
            chk("rdy_busy", tx0.in_ready, 0);
            chk("done_early", tx0.done, 0);
            if (i == glitch_at) begin
                tx0.in_valid = 1'b1;
                tx0.in_data  = 8'h3C;
            end else if (glitch_at >= 0 && i == glitch_at + 1) begin
                tx0.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", tx0.done, 1);
        chk("done_so", tx0.so, 1);
        chk("done_busy", tx0.busy, 0);
        chk("done_rdy", tx0.in_ready, 1);
    endtask

    initial begin
        reset_n      = 1'b0;
        tx0.in_valid = 1'b0;
        tx0.in_data  = '0;
        tx1.in_valid = 1'b0;
        tx1.in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_so", tx0.so, 1);
        chk("rst_rdy", tx0.in_ready, 1);
        chk("rst_busy", tx0.busy, 0);
        chk("rst_done", tx0.done, 0);
        chk("rst_so1", tx1.so, 1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_so", tx0.so, 1);

        // Single frame 0xA5 from idle.
        send0(8'hA5);
        run_frame(-1, -1);
        chk("acc_count1", acc_q.size(), 1);

        // Back-to-back with in_valid held: 0x00 then 0xFF.
        tx0.in_data  = 8'h00;
        tx0.in_valid = 1'b1;
        push_frame(8'h00, 1'b0);
        @(posedge clk);
        #1 tx0.in_data = 8'hFF;
        push_frame(8'hFF, 1'b0);
        run_frame(-1, -1);
        @(posedge clk);
        #1 tx0.in_valid = 1'b0;
        run_frame(-1, -1);
        chk("b2b_count", acc_q.size(), 3);
        if (acc_q.size() >= 3) chk("b2b_spacing", acc_q[2] - acc_q[1], F * C + 1);

        // in_valid pulse and in_data change mid-frame are ignored.
        n_acc = acc_q.size();
        send0(8'hA5);
        run_frame(10, -1);
        @(negedge clk);
        chk("glitch_busy", tx0.busy, 0);
        chk("glitch_so", tx0.so, 1);
        chk("glitch_done", tx0.done, 0);
        chk("no_extra_frame", acc_q.size(), n_acc + 1);

        // Reset during data bit 3 (frame bit 4).
        send0(8'hA5);
        run_frame(-1, 4 * C + 1);
        @(negedge clk);
        chk("rst_hold_so", tx0.so, 1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", tx0.done, 0);
            chk("post_rst_so", tx0.so, 1);
            chk("post_rst_rdy", tx0.in_ready, 1);
        end
        send0(8'h5A);
        run_frame(-1, -1);

        // One clock per bit: 0x81.
        tx1.in_data  = 8'h81;
        tx1.in_valid = 1'b1;
        push_frame(8'h81, 1'b1);
        @(posedge clk);
        #1 tx1.in_valid = 1'b0;
        for (int i = 0; i < F; i++) begin
            @(negedge clk);
            chk("c1_so", tx1.so, pop1());
            chk("c1_done_early", tx1.done, 0);
        end
        @(negedge clk);
        chk("c1_done", tx1.done, 1);
        chk("c1_busy", tx1.busy, 0);

        // Odd-weight word (parity 1 when enabled).
        send0(8'h07);
        run_frame(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
